// File: rtl/minibyte_cu_ext_if.sv
// Control/bus bundle between the minibyte control unit (master) and datapath (slave).
interface minibyte_cu_ext_if #(
    parameter int OPC_W    = 8,
    parameter int ALU_OP_W = 3
);
    logic [OPC_W-1:0]    ir_op_buss_in;
    logic                alu_flag_z_in;
    logic                alu_flag_n_in;
    logic                set_a_out;
    logic                set_m_out;
    logic                set_pc_out;
    logic                set_ir_out;
    logic                inc_pc_out;
    logic                addr_mux_out;
    logic [ALU_OP_W-1:0] alu_op_out;
    logic                we_out;
    logic                halt_out;
    logic                illegal_out;

    modport master (
        input  ir_op_buss_in, alu_flag_z_in, alu_flag_n_in,
        output set_a_out, set_m_out, set_pc_out, set_ir_out, inc_pc_out,
               addr_mux_out, alu_op_out, we_out, halt_out, illegal_out
    );

    modport slave (
        output ir_op_buss_in, alu_flag_z_in, alu_flag_n_in,
        input  set_a_out, set_m_out, set_pc_out, set_ir_out, inc_pc_out,
               addr_mux_out, alu_op_out, we_out, halt_out, illegal_out
    );
endinterface

// File: rtl/minibyte_cu_ext.sv
// Moore control unit for the extended minibyte ISA (fetch/decode/execute).
// Define MINIBYTE_CU_ILLEGAL_TRAP_EN to halt with illegal_out on unknown opcodes.
module minibyte_cu_ext #(
    parameter int OPC_W    = 8,
    parameter int ALU_OP_W = 3
) (
    input  logic              clk_in,
    input  logic              rst_in,
    minibyte_cu_ext_if.master cu
);
    localparam logic [4:0] ST_RESET = 5'd0;
    localparam logic [4:0] ST_F0    = 5'd1;
    localparam logic [4:0] ST_F1    = 5'd2;
    localparam logic [4:0] ST_F2    = 5'd3;
    localparam logic [4:0] ST_DEC   = 5'd4;
    localparam logic [4:0] ST_IMM0  = 5'd5;
    localparam logic [4:0] ST_IMM1  = 5'd6;
    localparam logic [4:0] ST_D0    = 5'd7;
    localparam logic [4:0] ST_D1    = 5'd8;
    localparam logic [4:0] ST_D2    = 5'd9;
    localparam logic [4:0] ST_D3    = 5'd10;
    localparam logic [4:0] ST_S0    = 5'd11;
    localparam logic [4:0] ST_S1    = 5'd12;
    localparam logic [4:0] ST_J0    = 5'd13;
    localparam logic [4:0] ST_J1    = 5'd14;
    localparam logic [4:0] ST_SK    = 5'd15;
    localparam logic [4:0] ST_HALT  = 5'd16;
`ifdef MINIBYTE_CU_ILLEGAL_TRAP_EN
    localparam logic [4:0] ST_ILL   = 5'd17;
`endif

    localparam logic [OPC_W-1:0] OP_NOP     = OPC_W'(8'h00);
    localparam logic [OPC_W-1:0] OP_LDA_IMM = OPC_W'(8'h01);
    localparam logic [OPC_W-1:0] OP_LDA_DIR = OPC_W'(8'h02);
    localparam logic [OPC_W-1:0] OP_STA_DIR = OPC_W'(8'h03);
    localparam logic [OPC_W-1:0] OP_ADD_IMM = OPC_W'(8'h04);
    localparam logic [OPC_W-1:0] OP_SUB_IMM = OPC_W'(8'h05);
    localparam logic [OPC_W-1:0] OP_AND_IMM = OPC_W'(8'h06);
    localparam logic [OPC_W-1:0] OP_OR_IMM  = OPC_W'(8'h07);
    localparam logic [OPC_W-1:0] OP_XOR_IMM = OPC_W'(8'h08);
    localparam logic [OPC_W-1:0] OP_JMP     = OPC_W'(8'h09);
    localparam logic [OPC_W-1:0] OP_JZ      = OPC_W'(8'h0A);
    localparam logic [OPC_W-1:0] OP_JN      = OPC_W'(8'h0B);
    localparam logic [OPC_W-1:0] OP_HLT     = OPC_W'(8'h0F);

    localparam logic [ALU_OP_W-1:0] ALU_PASS_A = ALU_OP_W'(3'b000);
    localparam logic [ALU_OP_W-1:0] ALU_PASS_B = ALU_OP_W'(3'b001);
    localparam logic [ALU_OP_W-1:0] ALU_ADD    = ALU_OP_W'(3'b010);
    localparam logic [ALU_OP_W-1:0] ALU_SUB    = ALU_OP_W'(3'b011);
    localparam logic [ALU_OP_W-1:0] ALU_AND    = ALU_OP_W'(3'b100);
    localparam logic [ALU_OP_W-1:0] ALU_OR     = ALU_OP_W'(3'b101);
    localparam logic [ALU_OP_W-1:0] ALU_XOR    = ALU_OP_W'(3'b110);

    logic [4:0]          state_q;
    logic [4:0]          state_d;
    logic [ALU_OP_W-1:0] imm_op_q;
    logic [ALU_OP_W-1:0] imm_op_d;

    // ALU code for the IMM0/IMM1 pair is captured at decode so those states stay Moore.
    always_comb begin
        imm_op_d = ALU_PASS_B;
        case (cu.ir_op_buss_in)
            OP_ADD_IMM: imm_op_d = ALU_ADD;
            OP_SUB_IMM: imm_op_d = ALU_SUB;
            OP_AND_IMM: imm_op_d = ALU_AND;
            OP_OR_IMM:  imm_op_d = ALU_OR;
            OP_XOR_IMM: imm_op_d = ALU_XOR;
            default:    imm_op_d = ALU_PASS_B;
        endcase
    end

    always_comb begin
        state_d = ST_F0;
        case (state_q)
            ST_RESET: state_d = ST_F0;
            ST_F0:    state_d = ST_F1;
            ST_F1:    state_d = ST_F2;
            ST_F2:    state_d = ST_DEC;
            ST_DEC: begin
                case (cu.ir_op_buss_in)
                    OP_NOP:                             state_d = ST_F0;
                    OP_LDA_IMM, OP_ADD_IMM, OP_SUB_IMM,
                    OP_AND_IMM, OP_OR_IMM, OP_XOR_IMM:  state_d = ST_IMM0;
                    OP_LDA_DIR, OP_STA_DIR:             state_d = ST_D0;
                    OP_JMP:                             state_d = ST_J0;
                    OP_JZ:  state_d = cu.alu_flag_z_in ? ST_J0 : ST_SK;
                    OP_JN:  state_d = cu.alu_flag_n_in ? ST_J0 : ST_SK;
                    OP_HLT:                             state_d = ST_HALT;
`ifdef MINIBYTE_CU_ILLEGAL_TRAP_EN
                    default:                            state_d = ST_ILL;
`else
                    default:                            state_d = ST_F0;
`endif
                endcase
            end
            ST_IMM0:  state_d = ST_IMM1;
            ST_IMM1:  state_d = ST_F0;
            ST_D0:    state_d = ST_D1;
            // LDA and STA share D0/D1; IR is stable here so the split happens late.
            ST_D1:    state_d = (cu.ir_op_buss_in == OP_STA_DIR) ? ST_S0 : ST_D2;
            ST_D2:    state_d = ST_D3;
            ST_D3:    state_d = ST_F0;
            ST_S0:    state_d = ST_S1;
            ST_S1:    state_d = ST_F0;
            ST_J0:    state_d = ST_J1;
            ST_J1:    state_d = ST_F0;
            ST_SK:    state_d = ST_F0;
            ST_HALT:  state_d = ST_HALT;
`ifdef MINIBYTE_CU_ILLEGAL_TRAP_EN
            ST_ILL:   state_d = ST_ILL;
`endif
            default:  state_d = ST_F0;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q  <= ST_RESET;
            imm_op_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_DEC) begin
                imm_op_q <= imm_op_d;
            end
        end
    end

    always_comb begin
        cu.set_a_out    = 1'b0;
        cu.set_m_out    = 1'b0;
        cu.set_pc_out   = 1'b0;
        cu.set_ir_out   = 1'b0;
        cu.inc_pc_out   = 1'b0;
        cu.addr_mux_out = 1'b0;
        cu.alu_op_out   = '0;
        cu.we_out       = 1'b0;
        cu.halt_out     = 1'b0;
        cu.illegal_out  = 1'b0;
        case (state_q)
            ST_F0: cu.alu_op_out = ALU_PASS_B;
            ST_F1: begin
                cu.set_ir_out = 1'b1;
                cu.alu_op_out = ALU_PASS_B;
            end
            ST_F2: begin
                cu.inc_pc_out = 1'b1;
                cu.alu_op_out = ALU_PASS_B;
            end
            ST_IMM0: cu.alu_op_out = imm_op_q;
            ST_IMM1: begin
                cu.set_a_out  = 1'b1;
                cu.inc_pc_out = 1'b1;
                cu.alu_op_out = imm_op_q;
            end
            ST_D0: cu.alu_op_out = ALU_PASS_B;
            ST_D1: begin
                cu.set_m_out  = 1'b1;
                cu.alu_op_out = ALU_PASS_B;
            end
            ST_D2: begin
                cu.addr_mux_out = 1'b1;
                cu.alu_op_out   = ALU_PASS_B;
            end
            ST_D3: begin
                cu.set_a_out    = 1'b1;
                cu.inc_pc_out   = 1'b1;
                cu.addr_mux_out = 1'b1;
                cu.alu_op_out   = ALU_PASS_B;
            end
            ST_S0: begin
                cu.addr_mux_out = 1'b1;
                cu.alu_op_out   = ALU_PASS_A;
                cu.we_out       = 1'b1;
            end
            ST_S1: begin
                cu.inc_pc_out   = 1'b1;
                cu.addr_mux_out = 1'b1;
                cu.alu_op_out   = ALU_PASS_A;
            end
            ST_J0: cu.alu_op_out = ALU_PASS_B;
            ST_J1: begin
                cu.set_pc_out = 1'b1;
                cu.alu_op_out = ALU_PASS_B;
            end
            ST_SK:   cu.inc_pc_out = 1'b1;
            ST_HALT: cu.halt_out   = 1'b1;
`ifdef MINIBYTE_CU_ILLEGAL_TRAP_EN
            ST_ILL: begin
                cu.halt_out    = 1'b1;
                cu.illegal_out = 1'b1;
            end
`endif
            default: ;
        endcase
    end
endmodule

// File: doc/minibyte_cu_ext.md
Name: minibyte_cu_ext

Overview:
Parametrised next-generation control unit for the minibyte CPU. It is a Moore FSM that sequences fetch, decode and execute for an extended instruction set:
- loads and stores
- immediate ALU ops
- unconditional and flag-conditional jumps
- halt

It drives the register latch, PC, address-mux, ALU-op and write-enable controls of the minibyte datapath, replacing the load-only control unit.

Parameters:
OPC_W, 8, opcode width on ir_op_buss_in; opcode values below are zero-extended to OPC_W.
ALU_OP_W, 3, width of alu_op_out (>=3); ALU codes are zero-extended.

Ports:
clk_in  input  1  clock, rising edge
rst_in  input  1  asynchronous reset, active-high
ir_op_buss_in  input  OPC_W  current IR contents; stable outside FETCH_1
alu_flag_z_in  input  1  ALU zero flag
alu_flag_n_in  input  1  ALU negative flag
set_a_out  output  1  latch A from main bus
set_m_out  output  1  latch M from main bus
set_pc_out  output  1  load PC from main bus
set_ir_out  output  1  latch IR from main bus
inc_pc_out  output  1  PC increment
addr_mux_out  output  1  memory address source: 0 = PC, 1 = M
alu_op_out  output  ALU_OP_W  ALU op code
we_out  output  1  memory write strobe
halt_out  output  1  CPU halted
illegal_out  output  1  halted on illegal opcode (macro only, else tied 0)

Behaviour:
- Reset and output timing:
  - rst_in=1 asynchronously forces state RESET.
  - All outputs are decoded from state only (Moore); in RESET every output is 0.
  - Unlisted outputs in a state are 0.
- Opcodes:
  - 00 NOP, 01 LDA_IMM, 02 LDA_DIR, 03 STA_DIR
  - 04 ADD_IMM, 05 SUB_IMM, 06 AND_IMM, 07 OR_IMM, 08 XOR_IMM
  - 09 JMP, 0A JZ, 0B JN, 0F HLT
  - Any other value, including nonzero upper bits, is illegal.
- ALU codes: 000 pass A, 001 pass B (memory), 010 add, 011 sub, 100 and, 101 or, 110 xor.
- Fetch and decode:
  - RESET->F0.
  - F0: alu=001.
  - F1: set_ir, alu=001.
  - F2: inc_pc, alu=001, ->DEC.
  - DEC: all 0. Dispatches on ir_op_buss_in; flags are sampled at this edge only.
- Per-opcode dispatch from DEC:
  - NOP: ->F0. Instruction length 4 cycles.
  - LDA_IMM and ALU_IMM:
    - IMM0: alu=op.
    - IMM1: set_a, inc_pc, alu=op, ->F0.
    - op is 001 for LDA, else the mapped ALU code.
  - LDA_DIR:
    - D0: alu=001.
    - D1: set_m, alu=001.
    - D2: addr_mux=1, alu=001.
    - D3: set_a, inc_pc, addr_mux=1, alu=001, ->F0.
  - STA_DIR:
    - D0, D1 as above. D1 branches on opcode: 03 ->S0, else ->D2.
    - S0: addr_mux=1, alu=000, we=1.
    - S1: inc_pc, addr_mux=1, alu=000, ->F0.
    - we_out is high exactly one cycle.
  - JMP, JZ with Z=1, JN with N=1 (taken):
    - J0: alu=001.
    - J1: set_pc, alu=001, ->F0.
  - JZ/JN not taken:
    - SK: inc_pc, ->F0. Skips the operand byte.
  - HLT: ->HALT. halt_out=1, all other controls 0, remains until reset.
  - Illegal opcode: treated as NOP (see macro).
- Boundary rules:
  - Any unencoded state value ->F0.
  - Reset mid-instruction aborts immediately; outputs are 0 while reset is held.
  - No two of set_pc/inc_pc/set_ir are ever high in the same cycle.

Optional Feature:
MINIBYTE_CU_ILLEGAL_TRAP_EN
- Defined: an illegal opcode in DEC goes to HALT with illegal_out=1 and halt_out=1, held until reset.
- Undefined: an illegal opcode behaves as NOP and illegal_out is constant 0.

Test Plan:
- Reset:
  - Stimulus: assert rst_in mid-D2.
  - Required: all outputs 0 at once; after deassert, F0 follows RESET in 1 cycle.
- LDA_IMM then ADD_IMM:
  - Stimulus: IR=01 then IR=04.
  - Required: alu_op 001 then 010 during IMM0/IMM1; set_a and inc_pc high in the same single cycle; each instruction 6 cycles.
- STA_DIR:
  - Stimulus: IR=03.
  - Required: set_m in D1; we_out=1 for exactly one cycle with addr_mux=1 and alu=000; back in F0 after 8 cycles from F0.
- Conditional jumps:
  - Stimulus: JZ with Z=1; JZ with Z=0; JN with N=1 and Z=0.
  - Required: set_pc pulse when taken; single inc_pc in SK when not taken; flag change after DEC ignored.
- HLT:
  - Stimulus: IR=0F.
  - Required: halt_out=1 and all controls 0 for 20+ cycles; rst_in pulse returns to RESET/F0.
- Illegal opcode:
  - Stimulus: IR=0xC3.
  - Required: with macro, halt_out=1 and illegal_out=1; without macro, F0 after DEC and illegal_out=0.
